// File: rtl/wr_bin_info.sv
// Transmit side of the bin-info exchange: snapshots nv_all/nb_all on start
// and streams them as two words (nv, then nb) over a valid/ready port.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_wrinfo_i  start request, sampled only while idle
//   done_wrinfo_o   one-cycle pulse after the nb word is accepted
//   busy_o          high from accepted start through the done pulse
//   nv_all_i        variable count to send
//   nb_all_i        clause/bin count to send
//   data_o          outgoing word, zero-extended
//   data_valid_o    data_o valid
//   data_ready_i    sink accepts the word when valid & ready
//   data_last_o     marks the nb word, qualified by data_valid_o
module wr_bin_info #(
  parameter int WIDTH_CLAUSES = 16,
  parameter int WIDTH_VARS    = 12,
  parameter int WIDTH_DATA    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_wrinfo_i,
  output logic                     done_wrinfo_o,
  output logic                     busy_o,
  input  logic [WIDTH_VARS-1:0]    nv_all_i,
  input  logic [WIDTH_CLAUSES-1:0] nb_all_i,
  output logic [WIDTH_DATA-1:0]    data_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic                     data_last_o
);

  if (WIDTH_DATA < WIDTH_VARS ||
      WIDTH_DATA < WIDTH_CLAUSES) begin : g_width_check
    $error("wr_bin_info: WIDTH_DATA narrower than a count field");
  end

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND_NV = 2'd1;
  localparam logic [1:0] S_SEND_NB = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [WIDTH_VARS-1:0]    nv_q;
  logic [WIDTH_VARS-1:0]    nv_nxt;
  logic [WIDTH_CLAUSES-1:0] nb_q;
  logic [WIDTH_CLAUSES-1:0] nb_nxt;

  logic [WIDTH_DATA-1:0]    data_nxt;
  logic                     valid_nxt;
  logic                     last_nxt;
  logic                     busy_nxt;
  logic                     done_nxt;

  // Next-state and capture logic.
  always_comb begin
    state_nxt = state;
    nv_nxt    = nv_q;
    nb_nxt    = nb_q;
    unique case (state)
      S_IDLE: begin
        if (start_wrinfo_i) begin
          state_nxt = S_SEND_NV;
          nv_nxt    = nv_all_i;
          nb_nxt    = nb_all_i;
        end
      end
      S_SEND_NV: begin
        if (data_ready_i) state_nxt = S_SEND_NB;
      end
      S_SEND_NB: begin
        if (data_ready_i) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so nothing
  // downstream sees a combinational path from ready or start.
  always_comb begin
    data_nxt  = '0;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    unique case (state_nxt)
      S_SEND_NV: begin
        data_nxt  = WIDTH_DATA'(nv_nxt);
        valid_nxt = 1'b1;
        busy_nxt  = 1'b1;
      end
      S_SEND_NB: begin
        data_nxt  = WIDTH_DATA'(nb_nxt);
        valid_nxt = 1'b1;
        last_nxt  = 1'b1;
        busy_nxt  = 1'b1;
      end
      S_DONE: begin
        busy_nxt  = 1'b1;
        done_nxt  = 1'b1;
      end
      default: begin
        data_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      nv_q          <= '0;
      nb_q          <= '0;
      data_o        <= '0;
      data_valid_o  <= 1'b0;
      data_last_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_wrinfo_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      nv_q          <= nv_nxt;
      nb_q          <= nb_nxt;
      data_o        <= data_nxt;
      data_valid_o  <= valid_nxt;
      data_last_o   <= last_nxt;
      busy_o        <= busy_nxt;
      done_wrinfo_o <= done_nxt;
    end
  end

endmodule

// File: tb/tb_wr_bin_info.sv
// Self-checking bench for wr_bin_info: directed scenarios plus a
// randomized run compared against a word-queue reference model.
module tb_wr_bin_info;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic        busy;
  logic [11:0] nv;
  logic [15:0] nb;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        last;

  int vectors = 0;
  int errors  = 0;

  wr_bin_info #(
    .WIDTH_CLAUSES(16),
    .WIDTH_VARS   (12),
    .WIDTH_DATA   (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_wrinfo_i(start),
    .done_wrinfo_o (done),
    .busy_o        (busy),
    .nv_all_i      (nv),
    .nb_all_i      (nb),
    .data_o        (data),
    .data_valid_o  (valid),
    .data_ready_i  (ready),
    .data_last_o   (last)
  );

  always #5 clk = ~clk;

  // {valid, last, busy, done}
  logic [3:0]  flags;
  logic [19:0] obs;
  assign flags = {valid, last, busy, done};
  assign obs   = {flags, data};

  // Reference model: words still to be delivered, plus pending done pulse.
  logic [15:0] mq[$];
  bit          mdone;

  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mdone = 1'b0;
    end else if (mdone) begin
      mdone = 1'b0;
    end else if (mq.size() > 0) begin
      if (ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) mdone = 1'b1;
      end
    end else if (start) begin
      mq.push_back({4'h0, nv});
      mq.push_back(nb);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    nv = '0; nb = '0;
    cyc(); cyc();
    vectors++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, 20'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      vectors++;
      if (obs !== 20'h0) begin
        errors++;
        $display("FAIL idle[%0d]: got %h want %h", i, obs, 20'h0);
      end
    end
  endtask

  task automatic test_basic();
    nv = 12'h0A3; nb = 16'h1234; ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    vectors++;
    if (obs !== {4'b1010, 16'h00A3}) begin
      errors++;
      $display("FAIL basic_nv: got %h want %h", obs, {4'b1010, 16'h00A3});
    end
    cyc();
    vectors++;
    if (obs !== {4'b1110, 16'h1234}) begin
      errors++;
      $display("FAIL basic_nb: got %h want %h", obs, {4'b1110, 16'h1234});
    end
    cyc();
    vectors++;
    if (flags !== 4'b0011) begin
      errors++;
      $display("FAIL basic_done: got %b want %b", flags, 4'b0011);
    end
    cyc();
    vectors++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL basic_idle: got %b want %b", flags, 4'b0000);
    end
  endtask

  task automatic test_backpressure();
    int dones;
    nv = 12'h0A3; nb = 16'h1234; ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs !== {4'b1010, 16'h00A3}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h want %h",
                 i, obs, {4'b1010, 16'h00A3});
      end
      if (i == 5) ready = 1'b1;
      cyc();
    end
    vectors++;
    if (obs !== {4'b1110, 16'h1234}) begin
      errors++;
      $display("FAIL bp_nb: got %h want %h", obs, {4'b1110, 16'h1234});
    end
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (done) dones++;
    end
    vectors++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL bp_done_count: got %0d want 1", dones);
    end
  endtask

  task automatic test_busy_ignore();
    int dones;
    int valids;
    nv = 12'h0A3; nb = 16'h1234; ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    nv = 12'hFFF; nb = 16'h5555;
    vectors++;
    if (obs !== {4'b1010, 16'h00A3}) begin
      errors++;
      $display("FAIL ign_nv: got %h want %h", obs, {4'b1010, 16'h00A3});
    end
    cyc();
    vectors++;
    if (obs !== {4'b1110, 16'h1234}) begin
      errors++;
      $display("FAIL ign_nb: got %h want %h", obs, {4'b1110, 16'h1234});
    end
    start = 1'b1;
    cyc();
    vectors++;
    if (flags !== 4'b0011) begin
      errors++;
      $display("FAIL ign_done: got %b want %b", flags, 4'b0011);
    end
    cyc();
    start = 1'b0;
    dones = 0; valids = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      if (valid) valids++;
      cyc();
    end
    vectors++;
    if (dones !== 0 || valids !== 0) begin
      errors++;
      $display("FAIL ign_no_second: got done=%0d valid=%0d want 0/0",
               dones, valids);
    end
  endtask

  task automatic test_reset_mid();
    nv = 12'h0A3; nb = 16'h1234; ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; ready = 1'b1;
    cyc();
    ready = 1'b0;
    vectors++;
    if (obs !== {4'b1110, 16'h1234}) begin
      errors++;
      $display("FAIL rmid_nb: got %h want %h", obs, {4'b1110, 16'h1234});
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vectors++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL rmid_clear: got %h want %h", obs, 20'h0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (flags !== 4'b0000) begin
        errors++;
        $display("FAIL rmid_quiet[%0d]: got %b want 0000", i, flags);
      end
    end
    rst = 1'b1; start = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    cyc();
    vectors++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL rst_start: got %b want 0000", flags);
    end
    nv = 12'h155; nb = 16'hBEEF; ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    vectors++;
    if (obs !== {4'b1010, 16'h0155}) begin
      errors++;
      $display("FAIL rmid_new_nv: got %h want %h", obs, {4'b1010, 16'h0155});
    end
    cyc();
    vectors++;
    if (obs !== {4'b1110, 16'hBEEF}) begin
      errors++;
      $display("FAIL rmid_new_nb: got %h want %h", obs, {4'b1110, 16'hBEEF});
    end
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back();
    nv = 12'h001; nb = 16'h0002; ready = 1'b1; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++;
      if (obs !== {4'b1010, 16'h0001}) begin
        errors++;
        $display("FAIL b2b_nv[%0d]: got %h want %h",
                 k, obs, {4'b1010, 16'h0001});
      end
      cyc();
      vectors++;
      if (obs !== {4'b1110, 16'h0002}) begin
        errors++;
        $display("FAIL b2b_nb[%0d]: got %h want %h",
                 k, obs, {4'b1110, 16'h0002});
      end
      cyc();
      vectors++;
      if (flags !== 4'b0011) begin
        errors++;
        $display("FAIL b2b_done[%0d]: got %b want 0011", k, flags);
      end
      cyc();
      vectors++;
      if (flags !== 4'b0000) begin
        errors++;
        $display("FAIL b2b_idle[%0d]: got %b want 0000", k, flags);
      end
    end
    start = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    logic [3:0]  exp_flags;
    logic [15:0] exp_data;
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(99) < 2);
      start = ($urandom_range(99) < 35);
      ready = ($urandom_range(99) < 60);
      nv    = 12'($urandom);
      nb    = 16'($urandom);
      cyc();
      exp_flags = {mq.size() > 0, mq.size() == 1,
                   (mq.size() > 0) || mdone, mdone};
      vectors++;
      if (flags !== exp_flags) begin
        errors++;
        $display("FAIL rnd_flags[%0d]: got %b want %b", i, flags, exp_flags);
      end
      if (mq.size() > 0) begin
        exp_data = mq[0];
        vectors++;
        if (data !== exp_data) begin
          errors++;
          $display("FAIL rnd_data[%0d]: got %h want %h", i, data, exp_data);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0; nv = '0; nb = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wr_bin_info.md
Name: wr_bin_info

Overview:
Transmit side of the bin-info exchange. It snapshots the whole-problem variable count (nv_all) and bin/clause count (nb_all) on a start pulse. It then streams them out as two words over a valid/ready data port toward the host/memory side. Completion is reported with a one-cycle done pulse. The block sits in bin_manager, opposite the bin-info read path, and is used when a bin's metadata is written back.

Parameters:
WIDTH_CLAUSES, 16, width of nb_all (clause/bin count)
WIDTH_VARS, 12, width of nv_all (variable count)
WIDTH_DATA, 16, width of output data word; must be >= max(WIDTH_CLAUSES, WIDTH_VARS), otherwise elaboration fails

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start_wrinfo_i  input  1  start request; one-cycle pulse or level, sampled only in IDLE
done_wrinfo_o  output  1  one-cycle pulse after the last word is accepted
busy_o  output  1  high from the accepted start until done_wrinfo_o inclusive
nv_all_i  input  WIDTH_VARS  variable count to send
nb_all_i  input  WIDTH_CLAUSES  clause/bin count to send
data_o  output  WIDTH_DATA  outgoing word
data_valid_o  output  1  data_o valid
data_ready_i  input  1  sink accepts the word when valid & ready
data_last_o  output  1  marks the final word (the nb_all word); qualified by data_valid_o

Behaviour:
- One clock; reset is synchronous and active-high (port rst, sampled on posedge clk).
- Reset values: done_wrinfo_o=0, busy_o=0, data_o=0, data_valid_o=0, data_last_o=0, FSM=IDLE, capture registers=0.
- FSM states: IDLE, SEND_NV, SEND_NB, DONE.
- IDLE:
  - If start_wrinfo_i=1 at a clock edge, capture nv_all_i and nb_all_i into internal registers and go to SEND_NV.
  - Inputs are ignored afterward until the next IDLE.
- SEND_NV:
  - data_o = zero-extended captured nv_all; data_valid_o=1; data_last_o=0; busy_o=1.
  - On the edge where data_ready_i=1, go to SEND_NB.
- SEND_NB:
  - data_o = zero-extended captured nb_all; data_valid_o=1; data_last_o=1.
  - On the edge where data_ready_i=1, go to DONE.
- DONE:
  - data_valid_o=0, done_wrinfo_o=1 for exactly this one cycle, busy_o=1.
  - Next state is IDLE unconditionally.
  - A start in DONE is ignored.
- Outputs are registered, with no combinational path from data_ready_i or start_wrinfo_i to any output.
- Latency:
  - First valid word appears the cycle after start is sampled.
  - With data_ready_i held high: start at edge N gives nv word in cycle N+1, nb word in cycle N+2, done in cycle N+3, IDLE in cycle N+4.
  - The earliest re-start is sampled at edge N+4 (3-cycle busy window).
- Handshake rules:
  - Once data_valid_o rises, it stays high and data_o/data_last_o stay stable until accepted.
  - data_ready_i while data_valid_o=0 has no effect.
  - Backpressure of any length is allowed.
- Zero-extension: the upper WIDTH_DATA-WIDTH_x bits of data_o are 0 for each word.
- start_wrinfo_i during SEND_NV, SEND_NB or DONE is ignored and not queued.
- Changes on nv_all_i/nb_all_i after capture do not affect the words sent.
- Reset mid-operation (any state): immediate return to reset values next cycle. No done pulse is issued and the partial transfer is abandoned.
- Simultaneous rst and start: rst wins, and the FSM stays in IDLE.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0; with start=0, data_valid_o stays 0 for 10 cycles.
- Basic transfer: nv_all_i=12'h0A3, nb_all_i=16'h1234, ready=1, start pulse at edge N -> cycle N+1: data_o=16'h00A3, last=0; cycle N+2: data_o=16'h1234, last=1; cycle N+3: done=1 for one cycle; busy high N+1..N+3.
- Backpressure: same values, ready=0 for 5 cycles then 1 -> 16'h00A3 held stable with valid=1 for 6 cycles before acceptance; nb word then sent; exactly one done pulse.
- Input change and start-while-busy: after capture, drive nv_all_i=12'hFFF and pulse start during SEND_NB -> words still 16'h00A3/16'h1234, only one done pulse, no second transfer.
- Reset mid-transfer: assert rst while in SEND_NB with ready=0 -> next cycle valid=0, last=0, busy=0; done never asserts; a new start after reset sends the freshly captured values.
- Back-to-back: start held high continuously, ready=1, values 12'h001/16'h0002 -> transfers repeat every 4 cycles, each ending in a single done pulse.
